// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op codes, FSM states and widths for the EX-stage mul/div unit
package muldiv_pkg;

    localparam int XLEN   = 32;
    localparam int CNT_W  = 5;
    localparam int PROD_W = 64;

    localparam logic [5:0] OP_MFHI  = 6'h10;
    localparam logic [5:0] OP_MTHI  = 6'h11;
    localparam logic [5:0] OP_MFLO  = 6'h12;
    localparam logic [5:0] OP_MTLO  = 6'h13;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1A;
    localparam logic [5:0] OP_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    function automatic logic is_muldiv_op(input logic [5:0] code);
        return (code == OP_MULT) || (code == OP_MULTU) ||
               (code == OP_DIV)  || (code == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add or restoring shift-subtract iteration
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic              is_div_i,
    input  logic [PROD_W-1:0] acc_i,
    input  logic [XLEN-1:0]   operand_i,
    output logic [PROD_W-1:0] acc_o
);

    logic [XLEN:0] add_sum;
    logic [XLEN:0] trial;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {remainder, dividend bits shifting into quotient}.
    always_comb begin
        add_sum = {1'b0, acc_i[PROD_W-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        trial   = acc_i[PROD_W-1:XLEN-1] - {1'b0, operand_i};
        acc_o   = {add_sum, acc_i[XLEN-1:1]};
        if (is_div_i) begin
            if (trial[XLEN]) begin
                acc_o = {acc_i[PROD_W-2:0], 1'b0};
            end else begin
                acc_o = {trial[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative MULT/DIV unit with HI/LO registers and pipeline stall
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             EX_valid,
    input  logic [5:0]       EX_alu_control,
    input  logic [WIDTH-1:0] EX_operand_a,
    input  logic [WIDTH-1:0] EX_operand_b,
    output logic             EX_muldiv_stall,
    output logic [WIDTH-1:0] EX_muldiv_result,
    output logic [WIDTH-1:0] EX_hi,
    output logic [WIDTH-1:0] EX_lo,
    output logic             EX_div_by_zero
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic [XLEN-1:0]   dividend_q, dividend_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [PROD_W-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;

    logic              start;
    logic              op_div, op_signed;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [PROD_W-1:0] step_acc;
    logic [PROD_W-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;
    logic              div_zero;

    muldiv_step u_step (
        .is_div_i  (is_div_q),
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .acc_o     (step_acc)
    );

    // Op-code bit 1 selects divide, bit 0 selects unsigned.
    always_comb begin
        start     = (state_q == IDLE) && EX_valid && is_muldiv_op(EX_alu_control);
        op_div    = EX_alu_control[1];
        op_signed = ~EX_alu_control[0];
        mag_a     = (op_signed && EX_operand_a[XLEN-1]) ? (~EX_operand_a + 1'b1) : EX_operand_a;
        mag_b     = (op_signed && EX_operand_b[XLEN-1]) ? (~EX_operand_b + 1'b1) : EX_operand_b;
    end

    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? (~acc_q + 1'b1) : acc_q;
        quot_fix = (neg_a_q ^ neg_b_q) ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_fix  = neg_a_q ? (~acc_q[PROD_W-1:XLEN] + 1'b1) : acc_q[PROD_W-1:XLEN];
        div_zero = is_div_q && (opnd_q == '0);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_a_d    = neg_a_q;
        neg_b_d    = neg_b_q;
        dividend_d = dividend_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = BUSY;
                    cnt_d      = '0;
                    is_div_d   = op_div;
                    neg_a_d    = op_signed && EX_operand_a[XLEN-1];
                    neg_b_d    = op_signed && EX_operand_b[XLEN-1];
                    dividend_d = EX_operand_a;
                    opnd_d     = op_div ? mag_b : mag_a;
                    acc_d      = {{XLEN{1'b0}}, (op_div ? mag_a : mag_b)};
                end else if (EX_valid && (EX_alu_control == OP_MTHI)) begin
                    hi_d = EX_operand_a;
                end else if (EX_valid && (EX_alu_control == OP_MTLO)) begin
                    lo_d = EX_operand_a;
                end
            end
            BUSY: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {CNT_W{1'b1}}) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (div_zero) begin
                    hi_d = dividend_q;
                    lo_d = {XLEN{1'b1}};
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[PROD_W-1:XLEN];
                    lo_d = prod_fix[XLEN-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            dividend_q <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_a_q    <= neg_a_d;
            neg_b_q    <= neg_b_d;
            dividend_q <= dividend_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    // Reads see the registered HI/LO, so an MTHI/MTLO in the same cycle is not forwarded.
    always_comb begin
        EX_muldiv_stall  = start || (state_q == BUSY);
        EX_div_by_zero   = (state_q == DONE) && div_zero;
        EX_hi            = hi_q;
        EX_lo            = lo_q;
        EX_muldiv_result = '0;
        if (EX_valid && (EX_alu_control == OP_MFHI)) begin
            EX_muldiv_result = hi_q;
        end else if (EX_valid && (EX_alu_control == OP_MFLO)) begin
            EX_muldiv_result = lo_q;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - scoreboard bench for ex_muldiv_unit
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        EX_valid = 1'b0;
    logic [5:0]  EX_alu_control = 6'h0;
    logic [31:0] EX_operand_a = 32'h0;
    logic [31:0] EX_operand_b = 32'h0;
    logic        EX_muldiv_stall;
    logic [31:0] EX_muldiv_result;
    logic [31:0] EX_hi;
    logic [31:0] EX_lo;
    logic        EX_div_by_zero;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .EX_valid         (EX_valid),
        .EX_alu_control   (EX_alu_control),
        .EX_operand_a     (EX_operand_a),
        .EX_operand_b     (EX_operand_b),
        .EX_muldiv_stall  (EX_muldiv_stall),
        .EX_muldiv_result (EX_muldiv_result),
        .EX_hi            (EX_hi),
        .EX_lo            (EX_lo),
        .EX_div_by_zero   (EX_div_by_zero)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a falling stall marks DONE; the following cycle shows new HI/LO and an MFHI read.
    logic prev_stall  = 1'b0;
    int   run_len     = 0;
    logic chk_pending = 1'b0;
    exp_t cur;

    always @(negedge clock) begin
        if (!reset) begin
            prev_stall  = 1'b0;
            run_len     = 0;
            chk_pending = 1'b0;
        end else begin
            if (chk_pending) begin
                check("hi", EX_hi, cur.hi);
                check("lo", EX_lo, cur.lo);
                check("mfhi_after_done", EX_muldiv_result, cur.hi);
                chk_pending = 1'b0;
            end
            if (prev_stall && !EX_muldiv_stall) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_pop: got completion, expected none queued");
                end else begin
                    cur = sb.pop_front();
                    check("stall_len", 32'(run_len), 32'd33);
                    check("dbz_done", {31'b0, EX_div_by_zero}, {31'b0, cur.dbz});
                    chk_pending = 1'b1;
                end
            end else if (EX_div_by_zero) begin
                total++;
                bad++;
                $display("FAIL dbz_spurious: got 1 expected 0");
            end
            if (EX_muldiv_stall) run_len++;
            else run_len = 0;
            prev_stall = EX_muldiv_stall;
        end
    end

    task automatic do_op(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
        exp_t e;
        logic done;
        e.hi = ehi;
        e.lo = elo;
        e.dbz = edbz;
        sb.push_back(e);
        @(posedge clock);
        #1;
        EX_valid = 1'b1;
        EX_alu_control = code;
        EX_operand_a = a;
        EX_operand_b = b;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clock);
            if (!EX_muldiv_stall) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL op_timeout: stall still high after 40 cycles, expected release");
        end
        @(posedge clock);
        #1;
        EX_alu_control = OP_MFHI;
        @(posedge clock);
        #1;
        EX_valid = 1'b0;
        EX_alu_control = 6'h0;
        repeat (2) @(posedge clock);
    endtask

    logic saw_stall;

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check("rst_hi", EX_hi, 32'h0);
        check("rst_lo", EX_lo, 32'h0);
        check("rst_stall", {31'b0, EX_muldiv_stall}, 32'h0);
        check("rst_dbz", {31'b0, EX_div_by_zero}, 32'h0);
        check("rst_result", EX_muldiv_result, 32'h0);

        // MTLO then MFLO, MTHI, never stalling
        @(posedge clock); #1;
        EX_valid = 1'b1; EX_alu_control = OP_MTLO; EX_operand_a = 32'h1234;
        @(negedge clock);
        check("mtlo_stall", {31'b0, EX_muldiv_stall}, 32'h0);
        @(posedge clock); #1;
        EX_alu_control = OP_MFLO; EX_operand_a = 32'h0;
        @(negedge clock);
        check("mflo_result", EX_muldiv_result, 32'h1234);
        check("mflo_stall", {31'b0, EX_muldiv_stall}, 32'h0);
        @(posedge clock); #1;
        EX_alu_control = OP_MTHI; EX_operand_a = 32'hAAAA;
        @(posedge clock); #1;

        // MULT with EX_valid low must be ignored
        EX_valid = 1'b0; EX_alu_control = OP_MULT; EX_operand_a = 32'd5; EX_operand_b = 32'd6;
        saw_stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (EX_muldiv_stall) saw_stall = 1'b1;
        end
        check("invalid_no_stall", {31'b0, saw_stall}, 32'h0);
        check("invalid_hi", EX_hi, 32'hAAAA);
        check("invalid_lo", EX_lo, 32'h1234);
        @(posedge clock); #1;
        EX_alu_control = 6'h0;

        do_op(OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        do_op(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
        do_op(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        do_op(OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        do_op(OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
        do_op(OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1);
        do_op(OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
        do_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);

        // Reset at T+10 of a MULT aborts it without writing HI/LO
        @(posedge clock); #1;
        EX_valid = 1'b1; EX_alu_control = OP_MULT; EX_operand_a = 32'd3; EX_operand_b = 32'd4;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b0;
        EX_valid = 1'b0;
        EX_alu_control = 6'h0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("abort_stall", {31'b0, EX_muldiv_stall}, 32'h0);
        check("abort_hi", EX_hi, 32'h0);
        check("abort_lo", EX_lo, 32'h0);

        do_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        repeat (4) @(posedge clock);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
